// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port-A arbiter: default widths, arbitration
// states and master index constants.
package ram_arb_pkg;

   localparam int ADDR_W_DEF = 30;
   localparam int DATA_W_DEF = 32;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic [1:0] {
      OPEN  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational 2-way round-robin picker. A held lock restricts the grant to
// the lock owner; otherwise a tie goes to the master that did not win last.
module ram_arb_pick
   import ram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  arb_state_t state,
   output logic [1:0] gnt
);

   // Select at most one requester from state, request vector and last winner.
   always_comb begin
      gnt = 2'b00;
      case (state)
         LOCK0:   gnt[0] = req[0];
         LOCK1:   gnt[1] = req[1];
         default: begin
            if (req[0] && req[1]) begin
               if (last == M1) gnt[0] = 1'b1;
               else            gnt[1] = 1'b1;
            end else begin
               gnt = req;
            end
         end
      endcase
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for port A of the shared word-addressed RAM.
// Master 0 is the CPU data-access stage, master 1 the debug/loader engine.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   OPEN  | round-robin between both masters
//   LOCK0 | master 0 holds the port; master 1 waits regardless of request
//   LOCK1 | master 1 holds the port; master 0 waits regardless of request
//
// Read data returns one cycle after acceptance and is steered to the master
// recorded in rd_owner. With no grant the address port keeps its last value
// so the RAM input does not toggle while idle.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clock,
   input  logic                reset_n,

   input  logic                m0_req,
   input  logic                m0_we,
   input  logic                m0_lock,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_be,
   output logic                m0_gnt,
   output logic                m0_rvalid,
   output logic [DATA_W-1:0]   m0_rdata,

   input  logic                m1_req,
   input  logic                m1_we,
   input  logic                m1_lock,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_be,
   output logic                m1_gnt,
   output logic                m1_rvalid,
   output logic [DATA_W-1:0]   m1_rdata,

   output logic                ram_wren,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W-1:0]   ram_data,
   output logic [DATA_W/8-1:0] ram_byteena,
   input  logic [DATA_W-1:0]   ram_q
);

   arb_state_t        state;
   arb_state_t        state_nx;
   logic              last;
   logic [1:0]        pick;
   logic [1:0]        gnt;
   logic              win;
   logic              acc_lock;
   logic [ADDR_W-1:0] addr_q;
   logic              rd_pending;
   logic              rd_owner;

   ram_arb_pick u_pick (
      .req   ({m1_req, m0_req}),
      .last  (last),
      .state (state),
      .gnt   (pick)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= OPEN;
      else          state <= state_nx;
   end

   // Lock entry on an accepted locked transfer; release on an unlocked
   // transfer or when the owner drops both request and lock.
   always_comb begin
      state_nx = state;
      if (|gnt) begin
         if (acc_lock) state_nx = win ? LOCK1 : LOCK0;
         else          state_nx = OPEN;
      end else begin
         case (state)
            LOCK0:   if (!m0_req && !m0_lock) state_nx = OPEN;
            LOCK1:   if (!m1_req && !m1_lock) state_nx = OPEN;
            default: state_nx = state;
         endcase
      end
   end

   // Grant gating and winner mux onto the RAM port.
   always_comb begin
      gnt         = pick & {2{reset_n}};
      win         = gnt[1];
      acc_lock    = win ? m1_lock : m0_lock;
      ram_data    = win ? m1_wdata : m0_wdata;
      ram_address = addr_q;
      ram_wren    = 1'b0;
      ram_byteena = '0;
      if (|gnt) begin
         ram_address = win ? m1_addr : m0_addr;
         ram_wren    = win ? m1_we   : m0_we;
         ram_byteena = win ? m1_be   : m0_be;
      end
   end

   // Last winner, held address and the one-deep read return tracker.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last       <= M1;
         addr_q     <= '0;
         rd_pending <= 1'b0;
         rd_owner   <= M0;
      end else begin
         rd_pending <= (|gnt) && !ram_wren;
         if (|gnt) begin
            last     <= win;
            addr_q   <= ram_address;
            rd_owner <= win;
         end
      end
   end

   assign m0_gnt    = gnt[0];
   assign m1_gnt    = gnt[1];
   assign m0_rvalid = rd_pending && (rd_owner == M0);
   assign m1_rvalid = rd_pending && (rd_owner == M1);
   assign m0_rdata  = m0_rvalid ? ram_q : '0;
   assign m1_rdata  = m1_rvalid ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small synchronous RAM model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_ram_port_arbiter;

   localparam int AW = 30;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          m0_req, m0_we, m0_lock;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic [3:0]    m0_be;
   logic          m0_gnt, m0_rvalid;
   logic [DW-1:0] m0_rdata;
   logic          m1_req, m1_we, m1_lock;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic [3:0]    m1_be;
   logic          m1_gnt, m1_rvalid;
   logic [DW-1:0] m1_rdata;
   logic          ram_wren;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data;
   logic [3:0]    ram_byteena;
   logic [DW-1:0] ram_q;

   logic [DW-1:0] mem [0:255];
   logic          mem_load;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .m0_req      (m0_req),
      .m0_we       (m0_we),
      .m0_lock     (m0_lock),
      .m0_addr     (m0_addr),
      .m0_wdata    (m0_wdata),
      .m0_be       (m0_be),
      .m0_gnt      (m0_gnt),
      .m0_rvalid   (m0_rvalid),
      .m0_rdata    (m0_rdata),
      .m1_req      (m1_req),
      .m1_we       (m1_we),
      .m1_lock     (m1_lock),
      .m1_addr     (m1_addr),
      .m1_wdata    (m1_wdata),
      .m1_be       (m1_be),
      .m1_gnt      (m1_gnt),
      .m1_rvalid   (m1_rvalid),
      .m1_rdata    (m1_rdata),
      .ram_wren    (ram_wren),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_byteena (ram_byteena),
      .ram_q       (ram_q)
   );

   // Port-A RAM model: byte-masked write, registered read.
   always @(posedge clock) begin
      if (mem_load) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
         mem[8'h10] <= 32'hDEAD_BEEF;
         mem[8'h20] <= 32'hAAAA_AAAA;
      end else if (ram_wren) begin
         for (int b = 0; b < 4; b++)
            if (ram_byteena[b]) mem[ram_address[7:0]][8*b +: 8] <= ram_data[8*b +: 8];
      end
      ram_q <= mem[ram_address[7:0]];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_gnt(input string tag, input logic [1:0] exp);
      chk({tag, ".gnt"}, {62'd0, m1_gnt, m0_gnt}, {62'd0, exp});
   endtask

   task automatic chk_rv(input string tag, input logic [1:0] exp_v, input logic [31:0] exp_d0,
                         input logic [31:0] exp_d1);
      chk({tag, ".rvalid"}, {62'd0, m1_rvalid, m0_rvalid}, {62'd0, exp_v});
      chk({tag, ".rdata0"}, {32'd0, m0_rdata}, {32'd0, exp_d0});
      chk({tag, ".rdata1"}, {32'd0, m1_rdata}, {32'd0, exp_d1});
   endtask

   task automatic set_m0(input logic req, input logic we, input logic lock, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [3:0] be);
      m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata; m0_be = be;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic lock, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [3:0] be);
      m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata; m1_be = be;
   endtask

   task automatic idle_all();
      set_m0(0, 0, 0, '0, '0, '0);
      set_m1(0, 0, 0, '0, '0, '0);
   endtask

   initial begin
      reset_n  = 1'b0;
      mem_load = 1'b1;
      idle_all();
      repeat (3) @(posedge clock);

      // Reset values; a request during reset must not be granted.
      @(negedge clock);
      set_m0(1, 0, 0, 30'h10, '0, '0);
      #1;
      chk_gnt("rst", 2'b00);
      chk_rv("rst", 2'b00, 0, 0);
      chk("rst.wren", {63'd0, ram_wren}, 64'd0);
      chk("rst.be", {60'd0, ram_byteena}, 64'd0);
      chk("rst.addr", {34'd0, ram_address}, 64'd0);

      // Single m0 read of 0x10.
      @(negedge clock);
      reset_n  = 1'b1;
      mem_load = 1'b0;
      set_m0(1, 0, 0, 30'h10, '0, '0);
      #1;
      chk_gnt("rd0", 2'b01);
      chk("rd0.addr", {34'd0, ram_address}, 64'h10);
      chk("rd0.wren", {63'd0, ram_wren}, 64'd0);
      @(negedge clock);
      idle_all();
      #1;
      chk_rv("rd0_ret", 2'b01, 32'hDEAD_BEEF, 0);
      chk_gnt("idle", 2'b00);
      chk("idle.wren", {63'd0, ram_wren}, 64'd0);
      chk("idle.be", {60'd0, ram_byteena}, 64'd0);
      chk("idle.addr_hold", {34'd0, ram_address}, 64'h10);
      @(negedge clock);
      #1;
      chk_rv("idle2", 2'b00, 0, 0);

      // Both masters reading back to back; m0 won last, so m1 leads.
      @(negedge clock);
      set_m0(1, 0, 0, 30'h30, '0, '0);
      set_m1(1, 0, 0, 30'h40, '0, '0);
      #1; chk_gnt("rr1", 2'b10);
      @(negedge clock);
      m1_addr = 30'h41;
      #1; chk_gnt("rr2", 2'b01); chk_rv("rr2", 2'b10, 0, 32'hC0DE_0040);
      @(negedge clock);
      m0_addr = 30'h31;
      #1; chk_gnt("rr3", 2'b10); chk_rv("rr3", 2'b01, 32'hC0DE_0030, 0);
      @(negedge clock);
      m1_addr = 30'h42;
      #1; chk_gnt("rr4", 2'b01); chk_rv("rr4", 2'b10, 0, 32'hC0DE_0041);
      @(negedge clock);
      idle_all();
      #1; chk_gnt("rr5", 2'b00); chk_rv("rr5", 2'b01, 32'hC0DE_0031, 0);

      // Byte-masked write by m1 then read-back by m0.
      @(negedge clock);
      set_m1(1, 1, 0, 30'h20, 32'h1122_3344, 4'b0101);
      #1;
      chk_gnt("wr", 2'b10);
      chk("wr.wren", {63'd0, ram_wren}, 64'd1);
      chk("wr.be", {60'd0, ram_byteena}, 64'h5);
      chk("wr.data", {32'd0, ram_data}, 64'h1122_3344);
      chk("wr.addr", {34'd0, ram_address}, 64'h20);
      @(negedge clock);
      set_m1(0, 0, 0, '0, '0, '0);
      set_m0(1, 0, 0, 30'h20, '0, '0);
      #1; chk_gnt("rbw", 2'b01); chk_rv("wr_norv", 2'b00, 0, 0);
      @(negedge clock);
      set_m0(0, 0, 0, '0, '0, '0);
      set_m1(1, 0, 0, 30'h20, '0, '0);
      #1; chk_gnt("rd1", 2'b10); chk_rv("rbw_ret", 2'b01, 32'hAA22_AA44, 0);

      // m0 locked sequence while m1 keeps requesting.
      @(negedge clock);
      set_m1(1, 0, 0, 30'h60, '0, '0);
      set_m0(1, 0, 1, 30'h50, '0, '0);
      #1; chk_gnt("lk1", 2'b01); chk_rv("rd1_ret", 2'b10, 0, 32'hAA22_AA44);
      @(negedge clock);
      m0_addr = 30'h51;
      #1; chk_gnt("lk2", 2'b01); chk_rv("lk2", 2'b01, 32'hC0DE_0050, 0);
      @(negedge clock);
      m0_addr = 30'h52; m0_lock = 1'b0;
      #1; chk_gnt("lk3", 2'b01); chk_rv("lk3", 2'b01, 32'hC0DE_0051, 0);
      @(negedge clock);
      set_m0(0, 0, 0, '0, '0, '0);
      #1; chk_gnt("lk_after", 2'b10); chk_rv("lk_after", 2'b01, 32'hC0DE_0052, 0);

      // Lock released by dropping req and lock: other master waits one cycle.
      @(negedge clock);
      set_m1(0, 0, 0, '0, '0, '0);
      set_m0(1, 0, 1, 30'h53, '0, '0);
      #1; chk_gnt("lk4", 2'b01); chk_rv("lk4", 2'b10, 0, 32'hC0DE_0060);
      @(negedge clock);
      set_m0(0, 0, 0, '0, '0, '0);
      set_m1(1, 0, 0, 30'h61, '0, '0);
      #1; chk_gnt("rel", 2'b00); chk_rv("rel", 2'b01, 32'hC0DE_0053, 0);
      @(negedge clock);
      #1; chk_gnt("rel_next", 2'b10); chk_rv("rel_next", 2'b00, 0, 0);

      // m1 lock held with req low blocks m0 until lock also drops.
      @(negedge clock);
      set_m1(1, 0, 1, 30'h62, '0, '0);
      #1; chk_gnt("lk1_a", 2'b10); chk_rv("lk1_a", 2'b10, 0, 32'hC0DE_0061);
      @(negedge clock);
      m1_req = 1'b0;
      set_m0(1, 0, 0, 30'h54, '0, '0);
      #1; chk_gnt("lk1_hold", 2'b00); chk_rv("lk1_hold", 2'b10, 0, 32'hC0DE_0062);
      @(negedge clock);
      m1_lock = 1'b0;
      #1; chk_gnt("lk1_rel", 2'b00);
      @(negedge clock);
      #1; chk_gnt("lk1_open", 2'b01); chk_rv("lk1_open", 2'b00, 0, 0);
      @(negedge clock);
      idle_all();
      #1; chk_rv("lk1_ret", 2'b01, 32'hC0DE_0054, 0);

      // Reset pulse right after an accepted read.
      @(negedge clock);
      set_m0(1, 0, 0, 30'h10, '0, '0);
      #1; chk_gnt("prerst", 2'b01);
      @(negedge clock);
      idle_all();
      reset_n = 1'b0;
      #1;
      chk_rv("midrst", 2'b00, 0, 0);
      chk("midrst.addr", {34'd0, ram_address}, 64'd0);
      chk("midrst.wren", {63'd0, ram_wren}, 64'd0);
      chk("midrst.be", {60'd0, ram_byteena}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      set_m0(1, 0, 0, 30'h10, '0, '0);
      set_m1(1, 0, 0, 30'h20, '0, '0);
      #1; chk_gnt("postrst_tie", 2'b01); chk_rv("postrst", 2'b00, 0, 0);
      @(negedge clock);
      set_m0(0, 0, 0, '0, '0, '0);
      #1; chk_gnt("postrst2", 2'b10); chk_rv("postrst2", 2'b01, 32'hDEAD_BEEF, 0);
      @(negedge clock);
      idle_all();
      #1;
      chk_gnt("final_idle", 2'b00);
      chk_rv("final_idle", 2'b10, 0, 32'hAA22_AA44);
      chk("final_idle.wren", {63'd0, ram_wren}, 64'd0);
      chk("final_idle.be", {60'd0, ram_byteena}, 64'd0);
      chk("final_idle.addr", {34'd0, ram_address}, 64'h20);
      @(negedge clock);
      #1; chk_rv("final_idle2", 2'b00, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-master arbiter sharing the single read/write port A of the word-addressed 32-bit RAM between the CPU data-access stage (master 0) and the debug/loader engine (master 1). Picks at most one request per cycle with round-robin fairness and an optional bus lock for atomic sequences. Drives the RAM port directly and routes the one-cycle-late read data back to the master that issued the read. Sits between the memory stage / loader and the RAM instance; port B (instruction fetch) is untouched.

## Interface
- ADDR_W, 30: word address width
- DATA_W, 32: data width; byte enable width is DATA_W/8
- clock  in  1  single clock, all flops on posedge
- reset_n  in  1  asynchronous, active-low reset
- mN_req  in  1  master N (N=0,1) request valid
- mN_we  in  1  1 = write, 0 = read
- mN_lock  in  1  keep ownership after this transfer
- mN_addr  in  ADDR_W  word address
- mN_wdata  in  DATA_W  write data
- mN_be  in  DATA_W/8  byte enables (writes only)
- mN_gnt  out  1  request accepted this cycle
- mN_rvalid  out  1  read data valid
- mN_rdata  out  DATA_W  read data
- ram_wren  out  1  to RAM wren_a
- ram_address  out  ADDR_W  to RAM address_a
- ram_data  out  DATA_W  to RAM data_a
- ram_byteena  out  DATA_W/8  to RAM byteena_a
- ram_q  in  DATA_W  from RAM q_a

## Operation
- Transfer accepted on a cycle where mN_req && mN_gnt; at most one gnt high per cycle.
- Grant is combinational from req, last-winner pointer and lock state; address/data/we/be of winner muxed combinationally onto ram_*.
- ram_wren = winner's we only when a grant is given; with no grant, ram_wren=0, ram_byteena=0, ram_address holds the last driven address (registered copy).
- Arbitration states: OPEN, LOCK0, LOCK1.
  - OPEN: one requester wins; both requesting -> master not granted last time wins; pointer resets to "master 1 last", so master 0 wins first tie.
  - Accepted transfer with mN_lock=1 -> LOCKN. Accepted with lock=0 -> OPEN.
  - LOCKN: only master N can be granted; other master waits regardless of req.
  - LOCKN -> OPEN on master N accepted transfer with lock=0, or on any cycle with mN_req=0 and mN_lock=0.
- Read return: 1-deep pipeline flop rd_owner/rd_pending set on accepted read; next cycle mN_rvalid=1 for owner, mN_rdata=ram_q. Non-owner rdata = 0.
- Writes produce no rvalid. Back-to-back reads sustain one per cycle; read directly after write to same address returns new data (RAM write lands at the same edge the address registers).

## Timing
- Reset (reset_n low, async): state=OPEN, pointer=master 1 last, rd_pending=0, both rvalid=0, rdata=0, gnt forced 0, ram_wren=0, ram_byteena=0, ram_address=0.
- Grant latency 0 cycles (same cycle as req) when eligible; read latency exactly 1 cycle after acceptance.
- Worst-case wait in OPEN: 1 cycle behind the other master; unbounded only while the other master holds lock.
- Masters hold req and all request fields stable until gnt.
- reset_n asserted mid-read: pending rvalid dropped, no response delivered.
- Simultaneous lock release by owner and req by other master: other master granted on the following cycle, not the same cycle.

## Structure
- Shared package ram_arb_pkg: ADDR_W/DATA_W defaults, state enum (OPEN, LOCK0, LOCK1), master index constants.
- One natural sub-module: ram_arb_pick — combinational 2-way round-robin picker (req[1:0], last, lock state -> gnt[1:0]).

## Test plan
- Reset then m0 read addr 0x10 (RAM holds 0xDEADBEEF) -> m0_gnt same cycle, m0_rvalid next cycle with 0xDEADBEEF, m1_rvalid=0.
- Both req continuously, reads -> grants alternate m0,m1,m0,...; each rvalid routed to correct master one cycle later.
- m1 write addr 0x20 data 0x11223344 be=4'b0101 over 0xAAAAAAAA, then m0 read 0x20 -> 0xAA22AA44.
- m0 three reads with lock=1,1,0 while m1 requests -> m1 gnt=0 for those three cycles, granted the cycle after.
- reset_n pulsed low the cycle after an accepted read -> no rvalid, all outputs at reset values, first post-reset tie goes to m0.
- Idle cycle (no req) -> ram_wren=0, ram_byteena=0, no gnt, no rvalid.
